jump_exec_unit: RTL and testbench

Executes one decoded JAL/JALR instruction per transaction, downstream of the jump decoder in the RISC-V core. Computes the jump target and the link value (pc+4), raises a one-cycle fetch redirect, holds a pipeline flush for a programmable number of cycles, and writes the link value to the register file over a valid/ready port. Misaligned targets raise an exception instead of redirecting.

---
 rtl/jump_exec_unit_pkg.sv | 34 +++
 rtl/jump_exec_unit_target_calc.sv | 53 +++++
 rtl/jump_exec_unit.sv | 181 ++++++++++++++++++
 tb/tb_jump_exec_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/jump_exec_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jump_exec_unit_pkg
// Description : Shared encodings for the jump execution unit: jump_control
//               codes, the JAL/JALR major opcodes and the FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package jump_exec_unit_pkg;

    // jump_control encodings produced by the jump decoder (2'b11 reserved)
    localparam logic [1:0] JUMP_NONE = 2'b00;
    localparam logic [1:0] JUMP_JAL  = 2'b01;
    localparam logic [1:0] JUMP_JALR = 2'b10;

    // RV32I major opcodes of the two jump instructions
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    // Execution FSM states, explicitly encoded
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REDIRECT = 3'd1,
        ST_FLUSH    = 3'd2,
        ST_WB_WAIT  = 3'd3,
        ST_EXC      = 3'd4
    } jeu_state_t;

    // True for the two encodings that describe a real jump
    function automatic logic is_jump(input logic [1:0] ctl);
        return (ctl == JUMP_JAL) || (ctl == JUMP_JALR);
    endfunction

endpackage : jump_exec_unit_pkg
`default_nettype wire

// File: rtl/jump_exec_unit_target_calc.sv
`default_nettype none
// ============================================================================
// Module      : jump_target_calc
// Description : Combinational jump target, link value and misalignment check.
//   i_pc            address of the jump instruction
//   i_rs1_data      JALR base register value
//   i_imm           21-bit immediate (JAL full, JALR in bits [11:0])
//   i_jump_control  jump kind
//   o_target        computed jump target
//   o_link          pc + 4
//   o_is_jump       jump_control is JAL or JALR
//   o_misaligned    target bit 1 set (no compressed instructions)
// Revision    : 1.0 - initial release
// ============================================================================
module jump_target_calc
    import jump_exec_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [20:0]     i_imm,
    input  logic [1:0]      i_jump_control,
    output logic [XLEN-1:0] o_target,
    output logic [XLEN-1:0] o_link,
    output logic            o_is_jump,
    output logic            o_misaligned
);

    logic [XLEN-1:0] w_imm_jal;
    logic [XLEN-1:0] w_imm_jalr;
    logic [XLEN-1:0] w_jalr_sum;

    // JAL uses the full 21-bit immediate; JALR only the low 12 bits, signed at bit 11
    assign w_imm_jal  = {{(XLEN-21){i_imm[20]}}, i_imm};
    assign w_imm_jalr = {{(XLEN-12){i_imm[11]}}, i_imm[11:0]};
    assign w_jalr_sum = i_rs1_data + w_imm_jalr;

    always_comb begin
        o_target = '0;
        case (i_jump_control)
            JUMP_JAL:  o_target = i_pc + w_imm_jal;
            JUMP_JALR: o_target = {w_jalr_sum[XLEN-1:1], 1'b0};
            default:   o_target = '0;
        endcase
    end

    assign o_link       = i_pc + XLEN'(4);
    assign o_is_jump    = is_jump(i_jump_control);
    assign o_misaligned = o_is_jump && o_target[1];

endmodule : jump_target_calc
`default_nettype wire

// File: rtl/jump_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : jump_exec_unit
// Description : Executes one JAL/JALR per transaction: fetch redirect strobe,
//               multi-cycle pipeline flush, link writeback over valid/ready,
//               and a misaligned-target exception instead of a redirect.
//   clk / rst_n         clock, asynchronous active-low reset
//   i_in_valid/o_in_ready   decoded jump handshake (ready only in IDLE)
//   i_pc, i_rs1_data, i_rd, i_imm, i_jump_control   decoded jump fields
//   o_redirect_valid/o_redirect_pc   one-cycle fetch redirect
//   o_flush             squash younger instructions
//   o_wb_valid/o_wb_rd/o_wb_data, i_wb_ready   link writeback port
//   o_misaligned_exc/o_exc_tval   one-cycle misaligned exception
// Revision    : 1.0 - initial release
// ============================================================================
module jump_exec_unit
    import jump_exec_unit_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [4:0]      i_rd,
    input  logic [20:0]     i_imm,
    input  logic [1:0]      i_jump_control,
    output logic            o_redirect_valid,
    output logic [XLEN-1:0] o_redirect_pc,
    output logic            o_flush,
    output logic            o_wb_valid,
    output logic [4:0]      o_wb_rd,
    output logic [XLEN-1:0] o_wb_data,
    input  logic            i_wb_ready,
    output logic            o_misaligned_exc,
    output logic [XLEN-1:0] o_exc_tval
);

    localparam int CW = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CW-1:0] c_FLUSH_LAST = CW'(FLUSH_CYCLES);

    jeu_state_t      r_state;
    jeu_state_t      w_state_next;
    logic [XLEN-1:0] r_target;
    logic [XLEN-1:0] r_link;
    logic [4:0]      r_rd;
    logic            r_wb_pending;
    logic [CW-1:0]   r_flush_cnt;

    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_link;
    logic            w_is_jump;
    logic            w_misaligned;
    logic            w_accept;
    logic            w_wb_accept;
    logic            w_flush_last;

    jump_target_calc #(
        .XLEN (XLEN)
    ) u_target_calc (
        .i_pc           (i_pc),
        .i_rs1_data     (i_rs1_data),
        .i_imm          (i_imm),
        .i_jump_control (i_jump_control),
        .o_target       (w_target),
        .o_link         (w_link),
        .o_is_jump      (w_is_jump),
        .o_misaligned   (w_misaligned)
    );

    assign w_accept     = i_in_valid && (r_state == ST_IDLE);
    assign w_wb_accept  = r_wb_pending && i_wb_ready;
    // r_flush_cnt holds the number of the flush cycle currently in progress
    assign w_flush_last = (r_flush_cnt >= c_FLUSH_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                // JUMP_NONE / reserved encodings are consumed without effect
                if (w_accept && w_is_jump) begin
                    w_state_next = w_misaligned ? ST_EXC : ST_REDIRECT;
                end
            end
            ST_REDIRECT, ST_FLUSH: begin
                if (!w_flush_last) begin
                    w_state_next = ST_FLUSH;
                end else if (!r_wb_pending || i_wb_ready) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_WB_WAIT;
                end
            end
            ST_WB_WAIT: begin
                if (!r_wb_pending || i_wb_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_EXC: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Transaction registers: latched target/link/rd, flush counter and
    // the writeback-outstanding flag (independent of the flush sequence
    // so the register file may accept during any flush cycle).
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_target     <= '0;
            r_link       <= '0;
            r_rd         <= '0;
            r_wb_pending <= 1'b0;
            r_flush_cnt  <= '0;
        end else begin
            if (w_accept && w_is_jump) begin
                r_target     <= w_target;
                r_link       <= w_link;
                r_rd         <= i_rd;
                r_wb_pending <= !w_misaligned && (i_rd != 5'd0);
                r_flush_cnt  <= CW'(1);
            end else begin
                if (w_wb_accept) begin
                    r_wb_pending <= 1'b0;
                end
                if (((r_state == ST_REDIRECT) || (r_state == ST_FLUSH)) && !w_flush_last) begin
                    r_flush_cnt <= r_flush_cnt + CW'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output logic (Moore, data fields gated to zero when not valid)
    // ------------------------------------------------------------------
    always_comb begin
        o_in_ready       = (r_state == ST_IDLE);
        o_redirect_valid = (r_state == ST_REDIRECT);
        o_redirect_pc    = '0;
        o_flush          = (r_state == ST_REDIRECT) || (r_state == ST_FLUSH);
        o_wb_valid       = r_wb_pending;
        o_wb_rd          = '0;
        o_wb_data        = '0;
        o_misaligned_exc = (r_state == ST_EXC);
        o_exc_tval       = '0;
        if (r_state == ST_REDIRECT) begin
            o_redirect_pc = r_target;
        end
        if (r_wb_pending) begin
            o_wb_rd   = r_rd;
            o_wb_data = r_link;
        end
        if (r_state == ST_EXC) begin
            o_exc_tval = r_target;
        end
    end

endmodule : jump_exec_unit
`default_nettype wire

// File: tb/tb_jump_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_jump_exec_unit
// Description : Directed self-checking bench for jump_exec_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jump_exec_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [4:0]  rd;
    logic [20:0] imm;
    logic [1:0]  jump_control;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_ready;
    logic        misaligned_exc;
    logic [31:0] exc_tval;

    int n_cmp = 0;
    int n_err = 0;

    jump_exec_unit #(
        .XLEN         (32),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_in_valid       (in_valid),
        .o_in_ready       (in_ready),
        .i_pc             (pc),
        .i_rs1_data       (rs1_data),
        .i_rd             (rd),
        .i_imm            (imm),
        .i_jump_control   (jump_control),
        .o_redirect_valid (redirect_valid),
        .o_redirect_pc    (redirect_pc),
        .o_flush          (flush),
        .o_wb_valid       (wb_valid),
        .o_wb_rd          (wb_rd),
        .o_wb_data        (wb_data),
        .i_wb_ready       (wb_ready),
        .o_misaligned_exc (misaligned_exc),
        .o_exc_tval       (exc_tval)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs and samples both land 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one jump for a single accepting edge, then withdraw it
    task automatic issue(input logic [1:0] ctl, input logic [31:0] p, input logic [31:0] r1,
                         input logic [4:0] d, input logic [20:0] im);
        jump_control = ctl;
        pc           = p;
        rs1_data     = r1;
        rd           = d;
        imm          = im;
        in_valid     = 1'b1;
        step();
        in_valid     = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        pc           = '0;
        rs1_data     = '0;
        rd           = '0;
        imm          = '0;
        jump_control = 2'b00;
        wb_ready     = 1'b1;
        #12;
        // Reset state
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_redirect", 32'(redirect_valid), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_exc", 32'(misaligned_exc), 32'd0);
        rst_n = 1'b1;
        step();

        // JAL pc=0x100 imm=0x10 rd=1, writeback accepted immediately
        issue(2'b01, 32'h100, 32'h0, 5'd1, 21'h000010);
        chk("jal_redirect_valid", 32'(redirect_valid), 32'd1);
        chk("jal_redirect_pc", redirect_pc, 32'h110);
        chk("jal_flush_n1", 32'(flush), 32'd1);
        chk("jal_wb_valid", 32'(wb_valid), 32'd1);
        chk("jal_wb_rd", 32'(wb_rd), 32'd1);
        chk("jal_wb_data", wb_data, 32'h104);
        chk("jal_in_ready_n1", 32'(in_ready), 32'd0);
        step();
        chk("jal_redirect_n2", 32'(redirect_valid), 32'd0);
        chk("jal_flush_n2", 32'(flush), 32'd1);
        chk("jal_wb_valid_n2", 32'(wb_valid), 32'd0);
        chk("jal_in_ready_n2", 32'(in_ready), 32'd0);
        step();
        chk("jal_flush_n3", 32'(flush), 32'd0);
        chk("jal_in_ready_n3", 32'(in_ready), 32'd1);

        // JALR rs1=0x2001 imm=0xFFF (-1) -> 0x2000 with bit0 cleared
        issue(2'b10, 32'h300, 32'h2001, 5'd5, 21'h000FFF);
        chk("jalr_redirect_pc", redirect_pc, 32'h2000);
        chk("jalr_wb_rd", 32'(wb_rd), 32'd5);
        chk("jalr_wb_data", wb_data, 32'h304);
        step();
        step();
        chk("jalr_in_ready_n3", 32'(in_ready), 32'd1);

        // JALR ignores imm[20:12]; rs1=0x1000, imm=0x1FF004 -> +4
        issue(2'b10, 32'h40, 32'h1000, 5'd6, 21'h1FF004);
        chk("jalr_hi_ignored", redirect_pc, 32'h1004);
        step();
        step();

        // Misaligned JAL pc=0x100 imm=2 -> exception, nothing else
        issue(2'b01, 32'h100, 32'h0, 5'd4, 21'h000002);
        chk("mis_exc", 32'(misaligned_exc), 32'd1);
        chk("mis_tval", exc_tval, 32'h102);
        chk("mis_redirect", 32'(redirect_valid), 32'd0);
        chk("mis_flush", 32'(flush), 32'd0);
        chk("mis_wb_valid", 32'(wb_valid), 32'd0);
        chk("mis_in_ready_n1", 32'(in_ready), 32'd0);
        step();
        chk("mis_exc_n2", 32'(misaligned_exc), 32'd0);
        chk("mis_in_ready_n2", 32'(in_ready), 32'd1);

        // rd=0: redirect and flush only
        issue(2'b01, 32'h400, 32'h0, 5'd0, 21'h000020);
        chk("rd0_redirect", 32'(redirect_valid), 32'd1);
        chk("rd0_redirect_pc", redirect_pc, 32'h420);
        chk("rd0_wb_valid_n1", 32'(wb_valid), 32'd0);
        step();
        chk("rd0_flush_n2", 32'(flush), 32'd1);
        chk("rd0_wb_valid_n2", 32'(wb_valid), 32'd0);
        step();
        chk("rd0_in_ready_n3", 32'(in_ready), 32'd1);

        // JUMP_NONE: consumed, nothing happens
        issue(2'b00, 32'h500, 32'h0, 5'd3, 21'h000010);
        chk("none_in_ready", 32'(in_ready), 32'd1);
        chk("none_redirect", 32'(redirect_valid), 32'd0);
        chk("none_wb_valid", 32'(wb_valid), 32'd0);

        // Wrap-around JAL with writeback stalled for 5 cycles
        wb_ready = 1'b0;
        issue(2'b01, 32'hFFFF_FFFC, 32'h0, 5'd3, 21'h000008);
        chk("wrap_redirect_pc", redirect_pc, 32'h4);
        for (int i = 1; i <= 5; i++) begin
            chk($sformatf("stall_wb_valid_n%0d", i), 32'(wb_valid), 32'd1);
            chk($sformatf("stall_wb_data_n%0d", i), wb_data, 32'h0);
            chk($sformatf("stall_wb_rd_n%0d", i), 32'(wb_rd), 32'd3);
            chk($sformatf("stall_in_ready_n%0d", i), 32'(in_ready), 32'd0);
            chk($sformatf("stall_flush_n%0d", i), 32'(flush), (i <= 2) ? 32'd1 : 32'd0);
            if (i < 5) step();
        end
        wb_ready = 1'b1;
        step();
        chk("stall_wb_valid_done", 32'(wb_valid), 32'd0);
        chk("stall_in_ready_done", 32'(in_ready), 32'd1);

        // Reset during the FLUSH cycle discards flush and writeback
        wb_ready = 1'b0;
        issue(2'b01, 32'h600, 32'h0, 5'd2, 21'h000010);
        step();
        chk("prerst_flush", 32'(flush), 32'd1);
        chk("prerst_wb_valid", 32'(wb_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_flush", 32'(flush), 32'd0);
        chk("arst_wb_valid", 32'(wb_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        #1;
        rst_n    = 1'b1;
        wb_ready = 1'b1;
        step();

        // Normal jump after reset
        issue(2'b01, 32'h500, 32'h0, 5'd7, 21'h000040);
        chk("post_redirect_pc", redirect_pc, 32'h540);
        chk("post_wb_data", wb_data, 32'h504);
        chk("post_wb_rd", 32'(wb_rd), 32'd7);
        step();
        step();
        chk("post_in_ready", 32'(in_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_jump_exec_unit
`default_nettype wire
